// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the two-requester APB master arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_ADDR_W = 9;
  localparam int APB_DATA_W = 8;

  // Identifies one of the two command sources (0 = req0, 1 = req1).
  typedef logic req_idx_t;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin pick: a lone request wins; on a tie the source not served last wins.
module apb_rr_arbiter
  import apb_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_idx_t   last_i,
  output req_idx_t   gnt_o,
  output logic       valid_o
);

  always_comb begin
    valid_o = |req_i;
    gnt_o   = 1'b0;
    if (req_i == 2'b11) begin
      gnt_o = ~last_i;
    end else if (req_i[1]) begin
      gnt_o = 1'b1;
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Two-source round-robin APB master; slave1 at PADDR[ADDR_W-1]=0, slave2 at 1.
// Define APB_ARB_TIMEOUT_EN to bound ACCESS wait states by TIMEOUT (error completion).
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL1,
  output logic              PSEL2,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  apb_state_e        state_q;
  req_idx_t          last_q;
  req_idx_t          cur_q;
  req_idx_t          gnt;
  logic              gnt_valid;
  logic [1:0]        req_masked;
  logic              psel1_q, psel2_q, penable_q, pwrite_q;
  logic              ack0_q, ack1_q, err_q;
  logic [ADDR_W-1:0] paddr_q, sel_addr;
  logic [DATA_W-1:0] pwdata_q, rdata_q, sel_wdata;
  logic              sel_wr;
  logic              timeout_hit;

  // A requester still holds req during its own ack cycle, so it is ignored there.
  assign req_masked = {req1 & ~ack1_q, req0 & ~ack0_q};

  apb_rr_arbiter u_arb (
    .req_i   (req_masked),
    .last_i  (last_q),
    .gnt_o   (gnt),
    .valid_o (gnt_valid)
  );

  assign sel_addr  = gnt ? addr1  : addr0;
  assign sel_wdata = gnt ? wdata1 : wdata0;
  assign sel_wr    = gnt ? wr1    : wr0;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_q;

  // Counts PREADY=0 cycles of the current ACCESS; zero on every ACCESS entry.
  always_ff @(posedge PCLK) begin
    if (PRESET || state_q != ACCESS) begin
      wait_q <= '0;
    end else if (!PREADY) begin
      wait_q <= wait_q + CNT_W'(1);
    end
  end

  assign timeout_hit = (state_q == ACCESS) && !PREADY && (wait_q == CNT_W'(TIMEOUT - 1));
`else
  // Constant 0 for any legal TIMEOUT: ACCESS waits on PREADY indefinitely.
  assign timeout_hit = (TIMEOUT < 0);
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      cur_q     <= 1'b0;
      psel1_q   <= 1'b0;
      psel2_q   <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            state_q  <= SETUP;
            cur_q    <= gnt;
            last_q   <= gnt;
            pwrite_q <= sel_wr;
            paddr_q  <= sel_addr;
            pwdata_q <= sel_wdata;
            psel1_q  <= ~sel_addr[ADDR_W-1];
            psel2_q  <= sel_addr[ADDR_W-1];
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          if (PREADY || timeout_hit) begin
            state_q   <= IDLE;
            psel1_q   <= 1'b0;
            psel2_q   <= 1'b0;
            penable_q <= 1'b0;
            ack0_q    <= ~cur_q;
            ack1_q    <= cur_q;
            // PREADY wins over a timeout reached in the same cycle.
            err_q     <= ~PREADY;
            if (!PREADY) begin
              rdata_q <= '0;
            end else if (!pwrite_q) begin
              rdata_q <= PRDATA;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign PSEL1     = psel1_q;
  assign PSEL2     = psel2_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: directed vector table, scheduled arbitration
// sequences checked against a transaction-level timing model, reset abort and timeout cases.
module tb_apb_master_arbiter;

  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 4;

  logic              PCLK = 1'b0;
  logic              PRESET;
  logic              req0, req1, wr0, wr1;
  logic [ADDR_W-1:0] addr0, addr1, PADDR;
  logic [DATA_W-1:0] wdata0, wdata1, rsp_rdata, PWDATA, PRDATA;
  logic              ack0, ack1, rsp_err, PSEL1, PSEL2, PENABLE, PWRITE, PREADY;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [DATA_W-1:0] model_rsp;
  int model_last;
  int sched_grants[$];
  int sched_setups[$];
  int sched_issued[2];
  int sched_acked[2];
  int n_access, got, stray;
  int exp_order[8] = '{0, 1, 0, 1, 0, 1, 0, 1};

  typedef struct {
    logic       sel;
    logic       wr;
    logic [8:0] addr;
    logic [7:0] wdata;
    int         waits;
    logic [7:0] prdata;
    logic       exp_psel1;
    logic       exp_psel2;
    logic [7:0] exp_rdata;
  } vec_t;
  vec_t vecs[6];

  apb_master_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "bench did not finish in time");
  end

  task automatic tick();
    @(negedge PCLK);
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_req(input logic r, input logic on, input logic wr,
                         input logic [8:0] a, input logic [7:0] d);
    if (!r) begin
      req0 = on; wr0 = wr; addr0 = a; wdata0 = d;
    end else begin
      req1 = on; wr1 = wr; addr1 = a; wdata1 = d;
    end
  endtask

  task automatic do_reset();
    PRESET = 1'b1; req0 = 1'b0; req1 = 1'b0; PREADY = 1'b0;
    tick();
    PRESET = 1'b0;
    model_rsp = '0;
    model_last = 1;
  endtask

  // One isolated transfer from IDLE, checked phase by phase.
  task automatic run_vec(input vec_t v);
    set_req(v.sel, 1'b1, v.wr, v.addr, v.wdata);
    PREADY = 1'b0; PRDATA = v.prdata;
    tick();
    chk("vec_setup_psel1", PSEL1, v.exp_psel1);
    chk("vec_setup_psel2", PSEL2, v.exp_psel2);
    chk("vec_setup_penable", PENABLE, 0);
    chk("vec_setup_paddr", PADDR, v.addr);
    chk("vec_setup_pwrite", PWRITE, v.wr);
    chk("vec_setup_pwdata", PWDATA, v.wdata);
    for (int i = 0; i <= v.waits; i++) begin
      tick();
      chk("vec_access_penable", PENABLE, 1);
      chk("vec_access_psel", {PSEL1, PSEL2}, {v.exp_psel1, v.exp_psel2});
      chk("vec_access_noack", {ack0, ack1}, 0);
      PREADY = (i == v.waits);
    end
    tick();
    chk("vec_ack", {ack0, ack1}, {~v.sel, v.sel});
    chk("vec_rdata", rsp_rdata, v.exp_rdata);
    chk("vec_err", rsp_err, 0);
    chk("vec_bus_idle", {PSEL1, PSEL2, PENABLE}, 0);
    $display("txn vec req%0d %s addr=%h rdata=%h", v.sel, v.wr ? "WR" : "RD", v.addr, rsp_rdata);
    PREADY = 1'b0;
    tick();
    chk("vec_ack_once", {ack0, ack1}, 0);
    chk("vec_masked", {PSEL1, PSEL2}, 0);
    set_req(v.sel, 1'b0, v.wr, v.addr, v.wdata);
    model_last = v.sel;
    if (!v.wr) model_rsp = v.prdata;
  endtask

  // Scheduled traffic: the model decides grants by round-robin rules and derives each
  // transfer's SETUP, ready and ack cycles from the latency rules.
  task automatic run_sched(input int nmax0, input int nmax1, input bit rnd, input int ncyc);
    bit active[2], granted[2], in_txn, p0, p1;
    int ack_at[2];
    logic cwr[2];
    logic [8:0] caddr[2];
    logic [7:0] cwd[2];
    int free_at, s_setup, s_ready, s_ack, s_req, waits, w, nmax;
    logic s_wr;
    logic [8:0] s_addr;
    logic [7:0] s_wd, s_prd;
    free_at = cyc; s_setup = -1; s_ready = -1; s_ack = -1; s_req = 0;
    s_wr = 1'b0; s_addr = '0; s_wd = '0; s_prd = '0;
    for (int r = 0; r < 2; r++) begin
      active[r] = 0; granted[r] = 0; ack_at[r] = -1; cwr[r] = 1'b0; caddr[r] = '0; cwd[r] = '0;
      sched_issued[r] = 0; sched_acked[r] = 0;
    end
    sched_grants.delete();
    sched_setups.delete();
    for (int step = 0; step < ncyc; step++) begin
      in_txn = (s_setup >= 0) && (cyc >= s_setup) && (cyc <= s_ready);
      chk("sch_psel1", PSEL1, in_txn && !s_addr[8]);
      chk("sch_psel2", PSEL2, in_txn && s_addr[8]);
      chk("sch_penable", PENABLE, in_txn && (cyc > s_setup));
      if ((PSEL1 || PSEL2) && !PENABLE) sched_setups.push_back(cyc);
      if (cyc == s_setup) begin
        chk("sch_paddr", PADDR, s_addr);
        chk("sch_pwrite", PWRITE, s_wr);
        chk("sch_pwdata", PWDATA, s_wd);
      end
      chk("sch_ack0", ack0, (cyc == s_ack) && (s_req == 0));
      chk("sch_ack1", ack1, (cyc == s_ack) && (s_req == 1));
      if (cyc == s_ack) begin
        if (!s_wr) model_rsp = s_prd;
        chk("sch_rdata", rsp_rdata, model_rsp);
        chk("sch_err", rsp_err, 0);
        active[s_req] = 0; granted[s_req] = 0; ack_at[s_req] = cyc; sched_acked[s_req]++;
        $display("txn sched req%0d %s addr=%h rdata=%h", s_req, s_wr ? "WR" : "RD", s_addr, rsp_rdata);
      end
      for (int r = 0; r < 2; r++) begin
        nmax = (r == 0) ? nmax0 : nmax1;
        if (!active[r] && ack_at[r] != cyc && sched_issued[r] < nmax &&
            (!rnd || ($urandom_range(0, 3) == 0 && step < ncyc - 30))) begin
          active[r] = 1; sched_issued[r]++;
          cwr[r] = 1'($urandom_range(0, 1)); caddr[r] = 9'($urandom); cwd[r] = 8'($urandom);
        end
        set_req(r[0], active[r] || (ack_at[r] == cyc), cwr[r], caddr[r], cwd[r]);
      end
      if (cyc >= free_at) begin
        p0 = active[0] && !granted[0];
        p1 = active[1] && !granted[1];
        if (p0 || p1) begin
          w = (p0 && p1) ? ((model_last == 0) ? 1 : 0) : (p1 ? 1 : 0);
          waits = rnd ? int'($urandom_range(0, 2)) : 0;
          s_setup = cyc + 1; s_ready = cyc + 2 + waits; s_ack = cyc + 3 + waits; free_at = s_ack;
          s_req = w; s_wr = cwr[w]; s_addr = caddr[w]; s_wd = cwd[w]; s_prd = 8'($urandom);
          granted[w] = 1; model_last = w; sched_grants.push_back(w);
        end
      end
      PREADY = (cyc == s_ready);
      PRDATA = s_prd;
      tick();
    end
    req0 = 1'b0; req1 = 1'b0; PREADY = 1'b0;
    tick();
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 9'h012, 8'hA5, 0, 8'h00, 1'b1, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 9'h105, 8'h00, 2, 8'h3C, 1'b0, 1'b1, 8'h3C};
    vecs[2] = '{1'b0, 1'b0, 9'h0FF, 8'h00, 1, 8'h81, 1'b1, 1'b0, 8'h81};
    vecs[3] = '{1'b1, 1'b1, 9'h1AA, 8'h5A, 3, 8'hEE, 1'b0, 1'b1, 8'h81};
    vecs[4] = '{1'b0, 1'b0, 9'h100, 8'h00, 0, 8'hC3, 1'b0, 1'b1, 8'hC3};
    vecs[5] = '{1'b1, 1'b1, 9'h000, 8'h0F, 0, 8'h44, 1'b1, 1'b0, 8'hC3};

    PRESET = 1'b1;
    req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    PREADY = 1'b0; PRDATA = '0;
    tick();
    tick();
    chk("reset_outputs", {PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, ack0, ack1, rsp_rdata, rsp_err}, 0);
    PRESET = 1'b0;
    model_rsp = '0;
    model_last = 1;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Same requester back-to-back: one masked IDLE cycle, SETUPs four cycles apart.
    run_sched(2, 0, 1'b0, 15);
    chk("b2b_acks", sched_acked[0], 2);
    chk("b2b_setup_count", sched_setups.size(), 2);
    if (sched_setups.size() >= 2) chk("b2b_setup_gap", sched_setups[1] - sched_setups[0], 4);

    // Simultaneous requests after reset: strict alternation starting with req0.
    do_reset();
    run_sched(4, 4, 1'b0, 40);
    chk("arb_grant_count", sched_grants.size(), 8);
    for (int i = 0; i < 8 && i < sched_grants.size(); i++) chk("arb_order", sched_grants[i], exp_order[i]);
    chk("arb_acks0", sched_acked[0], 4);
    chk("arb_acks1", sched_acked[1], 4);

    run_sched(1000, 1000, 1'b1, 600);
    chk("rnd_acks0", sched_acked[0], sched_issued[0]);
    chk("rnd_acks1", sched_acked[1], sched_issued[1]);

    // Reset in ACCESS: transfer aborted, no ack, pointer back to favour req0.
    set_req(1'b0, 1'b1, 1'b0, 9'h033, 8'h00);
    PREADY = 1'b0; PRDATA = 8'h99;
    tick();
    tick();
    chk("rst_in_access", PENABLE, 1);
    PRESET = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 9'h033, 8'h00);
    tick();
    chk("rst_outputs_zero", {PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, ack0, ack1, rsp_rdata, rsp_err}, 0);
    PRESET = 1'b0;
    stray = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ack0 || ack1 || PSEL1 || PSEL2) stray++;
    end
    chk("rst_no_ack", stray, 0);
    set_req(1'b0, 1'b1, 1'b1, 9'h044, 8'h11);
    set_req(1'b1, 1'b1, 1'b1, 9'h155, 8'h22);
    tick();
    chk("rst_tie_paddr", PADDR, 9'h044);
    chk("rst_tie_psel1", {PSEL1, PSEL2}, 2'b10);
    tick();
    PREADY = 1'b1;
    tick();
    chk("rst_tie_ack0", {ack0, ack1}, 2'b10);
    set_req(1'b0, 1'b0, 1'b1, 9'h044, 8'h11);
    set_req(1'b1, 1'b0, 1'b1, 9'h155, 8'h22);
    PREADY = 1'b0;
    tick();

    // PREADY stuck low.
    set_req(1'b1, 1'b1, 1'b0, 9'h1C0, 8'h00);
    PRDATA = 8'h77;
    tick();
`ifdef APB_ARB_TIMEOUT_EN
    n_access = 0; got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      tick();
      if (ack1) got = 1;
      else if (PENABLE) n_access++;
    end
    chk("to_ack_seen", got, 1);
    chk("to_access_cycles", n_access, TIMEOUT);
    chk("to_err", rsp_err, 1);
    chk("to_rdata", rsp_rdata, 0);
    tick();
    set_req(1'b1, 1'b0, 1'b0, 9'h1C0, 8'h00);
    chk("to_ack_once", {ack0, ack1}, 0);
`else
    stray = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ack0 || ack1) stray++;
    end
    chk("nto_no_ack", stray, 0);
    chk("nto_penable_held", PENABLE, 1);
    chk("nto_err", rsp_err, 0);
    set_req(1'b1, 1'b0, 1'b0, 9'h1C0, 8'h00);
    do_reset();
    chk("nto_reset_clears", {PSEL1, PSEL2, PENABLE}, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
